// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage:
// op codes, FSM states and status-register bit positions.
package wb_pkg;

   localparam int WIDTH = 20;
   localparam int HALF  = 10;
   localparam int AW    = 4;

   localparam int SR_Z = 0;
   localparam int SR_S = 1;
   localparam int SR_C = 2;

   typedef enum logic [2:0] {
      WB_NONE  = 3'd0,
      WB_ONE   = 3'd1,
      WB_SWAP  = 3'd2,
      WB_FLAGS = 3'd3,
      WB_LDSR  = 3'd4,
      WB_XORSR = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB_A = 2'd1,
      WB_B = 2'd2
   } state_t;

   // Unused encodings 6..7 behave as NONE.
   function automatic op_t norm_op(logic [2:0] op);
      return (op > 3'd5) ? WB_NONE : op_t'(op);
   endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback packet channel with valid/ready handshake.
// master = ALU side, slave = writeback stage.
interface alu_writeback_if #(
   parameter int WIDTH = wb_pkg::WIDTH,
   parameter int AW    = wb_pkg::AW
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic             in_mode;
   logic [AW-1:0]    in_dst_a;
   logic [AW-1:0]    in_dst_b;
   logic [WIDTH-1:0] in_res_a;
   logic [WIDTH-1:0] in_res_b;
   logic             in_zero;
   logic             in_sign;
   logic             in_carry;
   logic [2:0]       in_fmask;

   modport master (
      output in_valid, in_op, in_mode, in_dst_a, in_dst_b,
      output in_res_a, in_res_b, in_zero, in_sign, in_carry, in_fmask,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_op, in_mode, in_dst_a, in_dst_b,
      input  in_res_a, in_res_b, in_zero, in_sign, in_carry, in_fmask,
      output in_ready
   );
endinterface

// File: rtl/alu_writeback_status_reg.sv
// Carry/sign/zero status register with masked-flag,
// load and xor update paths.
module status_reg
   import wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       upd,
   input  op_t        op,
   input  logic [2:0] fmask,
   input  logic [2:0] flags,
   input  logic [2:0] res,
   output logic [2:0] sr
);

   logic [2:0] nxt;

   // Select the next status value for the held op.
   always_comb begin
      nxt = sr;
      case (op)
         WB_ONE, WB_SWAP, WB_FLAGS:
            nxt = (sr & ~fmask) | (flags & fmask);
         WB_LDSR:  nxt = res;
         WB_XORSR: nxt = sr ^ res;
         default:  nxt = sr;
      endcase
   end

   // Commit only on the strobe from the first writeback cycle.
   always_ff @(posedge clk) begin
      if (rst)      sr <= 3'b000;
      else if (upd) sr <= nxt;
   end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: holds one ALU packet, writes one or two
// results to the register file and drives the status register.
module alu_writeback
   import wb_pkg::*;
#(
   parameter int WIDTH = wb_pkg::WIDTH,
   parameter int HALF  = wb_pkg::HALF,
   parameter int AW    = wb_pkg::AW
) (
   input  logic             clk,
   input  logic             rst,
   alu_writeback_if.slave   up,
   output logic             rf_we,
   output logic [AW-1:0]    rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic [2:0]       sr,
   output logic             busy
);

   state_t           state;
   op_t              h_op;
   logic             h_mode;
   logic [AW-1:0]    h_dst_a;
   logic [AW-1:0]    h_dst_b;
   logic [WIDTH-1:0] h_res_a;
   logic [WIDTH-1:0] h_res_b;
   logic [2:0]       h_flags;
   logic [2:0]       h_fmask;

   logic             two_wr;
   logic             acc;
   logic             wr_a;
   logic [WIDTH-1:0] raw;

   // A swap onto one register collapses to a single write.
   assign two_wr = (h_op == WB_SWAP) && (h_dst_a != h_dst_b);

   assign up.in_ready = (state == IDLE)
                     || (state == WB_A && !two_wr);
   assign acc  = up.in_valid && up.in_ready;
   assign busy = (state != IDLE);

   // Sequencer and holding register; a new packet may
   // replace the held one at the end of its WB_A cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         h_op    <= WB_NONE;
         h_mode  <= 1'b0;
         h_dst_a <= '0;
         h_dst_b <= '0;
         h_res_a <= '0;
         h_res_b <= '0;
         h_flags <= 3'b000;
         h_fmask <= 3'b000;
      end else begin
         if (acc) begin
            h_op    <= norm_op(up.in_op);
            h_mode  <= up.in_mode;
            h_dst_a <= up.in_dst_a;
            h_dst_b <= up.in_dst_b;
            h_res_a <= up.in_res_a;
            h_res_b <= up.in_res_b;
            h_flags <= {up.in_carry, up.in_sign, up.in_zero};
            h_fmask <= up.in_fmask;
         end
         case (state)
            IDLE:    state <= acc ? WB_A : IDLE;
            WB_A: begin
               if (acc)         state <= WB_A;
               else if (two_wr) state <= WB_B;
               else             state <= IDLE;
            end
            WB_B:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign wr_a  = (state == WB_A)
               && (h_op == WB_ONE || h_op == WB_SWAP);
   assign rf_we = !rst && (wr_a || state == WB_B);

   // Pick address and unmasked data for the current write slot.
   always_comb begin
      raw      = '0;
      rf_waddr = '0;
      unique case (1'b1)
         (state == WB_A): begin
            rf_waddr = h_dst_a;
            raw      = h_res_a;
         end
         (state == WB_B): begin
            rf_waddr = h_dst_b;
            raw      = h_res_b;
         end
         default: begin
            rf_waddr = '0;
            raw      = '0;
         end
      endcase
   end

   assign rf_wdata = h_mode ? raw
                   : {{(WIDTH-HALF){1'b0}}, raw[HALF-1:0]};

   status_reg u_sr (
      .clk   (clk),
      .rst   (rst),
      .upd   (state == WB_A),
      .op    (h_op),
      .fmask (h_fmask),
      .flags (h_flags),
      .res   (h_res_a[2:0]),
      .sr    (sr)
   );

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed table,
// hand-written multi-cycle sequences and a random stream.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [19:0] rf_wdata;
   logic [2:0]  sr;
   logic        busy;

   int total  = 0;
   int passed = 0;

   alu_writeback_if #(.WIDTH(20), .AW(4)) bus ();

   alu_writeback dut (
      .clk      (clk),
      .rst      (rst),
      .up       (bus),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .sr       (sr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic        mode;
      logic [3:0]  dst;
      logic [19:0] res;
      logic [2:0]  flags;
      logic [2:0]  fmask;
      logic        we;
      logic [3:0]  waddr;
      logic [19:0] wdata;
      logic [2:0]  sr;
   } vec_t;

   vec_t vt[10];

   // Reference model state for the random stream.
   logic [23:0] q[$];
   logic [2:0]  msr;
   bit          pend;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(input logic [2:0] op, input logic mode,
                          input logic [3:0] da, input logic [3:0] db,
                          input logic [19:0] ra, input logic [19:0] rb,
                          input logic [2:0] fl, input logic [2:0] fm);
      bus.in_op    = op;
      bus.in_mode  = mode;
      bus.in_dst_a = da;
      bus.in_dst_b = db;
      bus.in_res_a = ra;
      bus.in_res_b = rb;
      bus.in_carry = fl[2];
      bus.in_sign  = fl[1];
      bus.in_zero  = fl[0];
      bus.in_fmask = fm;
   endtask

   function automatic logic [19:0] hmask(logic m, logic [19:0] r);
      return m ? r : 20'(r % 1024);
   endfunction

   // Apply the architectural effect of one accepted packet.
   task automatic model(input logic [2:0] op, input logic m,
                        input logic [3:0] da, input logic [3:0] db,
                        input logic [19:0] ra, input logic [19:0] rb,
                        input logic [2:0] fl, input logic [2:0] fm);
      int o;
      o = (op > 5) ? 0 : int'(op);
      if (o == 1 || o == 2) q.push_back({da, hmask(m, ra)});
      if (o == 2 && da != db) q.push_back({db, hmask(m, rb)});
      for (int k = 0; k < 3; k++)
         if ((o == 1 || o == 2 || o == 3) && fm[k]) msr[k] = fl[k];
      if (o == 4) msr = ra[2:0];
      if (o == 5) msr = msr ^ ra[2:0];
   endtask

   task automatic rcycle(input bit allow_new);
      logic [23:0] e;
      @(posedge clk);
      #1;
      if (!pend) begin
         bus.in_valid = allow_new && ($urandom_range(0, 3) != 0);
         set_pkt(3'($urandom_range(0, 7)), 1'($urandom),
                 4'($urandom), 4'($urandom_range(0, 3)),
                 20'($urandom), 20'($urandom),
                 3'($urandom), 3'($urandom));
         if ($urandom_range(0, 2) == 0) bus.in_dst_b = bus.in_dst_a;
      end
      @(negedge clk);
      if (rf_we) begin
         if (q.size() == 0) chk("rnd_extra_write", 1, 0);
         else begin
            e = q.pop_front();
            chk("rnd_waddr", rf_waddr, e[23:20]);
            chk("rnd_wdata", rf_wdata, e[19:0]);
         end
      end
      if (bus.in_valid && bus.in_ready)
         model(bus.in_op, bus.in_mode, bus.in_dst_a, bus.in_dst_b,
               bus.in_res_a, bus.in_res_b,
               {bus.in_carry, bus.in_sign, bus.in_zero}, bus.in_fmask);
      pend = bus.in_valid && !bus.in_ready;
   endtask

   initial begin
      vt[0] = '{3'd1, 1'b1, 4'd3, 20'hABCDE, 3'b001, 3'b001,
                1'b1, 4'd3, 20'hABCDE, 3'b001};
      vt[1] = '{3'd1, 1'b0, 4'd5, 20'hFFFFF, 3'b111, 3'b000,
                1'b1, 4'd5, 20'h003FF, 3'b001};
      vt[2] = '{3'd4, 1'b1, 4'd0, 20'h00005, 3'b000, 3'b000,
                1'b0, 4'd0, 20'h0, 3'b101};
      vt[3] = '{3'd4, 1'b1, 4'd0, 20'hFFFFA, 3'b000, 3'b000,
                1'b0, 4'd0, 20'h0, 3'b010};
      vt[4] = '{3'd5, 1'b1, 4'd0, 20'h00003, 3'b000, 3'b000,
                1'b0, 4'd0, 20'h0, 3'b001};
      vt[5] = '{3'd3, 1'b1, 4'd0, 20'h00000, 3'b110, 3'b100,
                1'b0, 4'd0, 20'h0, 3'b101};
      vt[6] = '{3'd0, 1'b1, 4'd1, 20'h00007, 3'b000, 3'b111,
                1'b0, 4'd0, 20'h0, 3'b101};
      vt[7] = '{3'd7, 1'b1, 4'd1, 20'h00002, 3'b000, 3'b111,
                1'b0, 4'd0, 20'h0, 3'b101};
      vt[8] = '{3'd1, 1'b0, 4'd9, 20'h12345, 3'b010, 3'b111,
                1'b1, 4'd9, 20'h00345, 3'b010};
      vt[9] = '{3'd5, 1'b0, 4'd0, 20'hFFFF7, 3'b000, 3'b000,
                1'b0, 4'd0, 20'h0, 3'b101};

      rst = 1'b1;
      bus.in_valid = 1'b1;
      set_pkt(3'd1, 1'b1, 4'd7, 4'd7, 20'h12345, 20'h0, 3'b111, 3'b111);
      tick();
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_sr", sr, 0);

      // Table: one packet from idle, then let it drain.
      for (int i = 0; i < 10; i++) begin
         set_pkt(vt[i].op, vt[i].mode, vt[i].dst, vt[i].dst + 4'd1,
                 vt[i].res, 20'hFFFFF, vt[i].flags, vt[i].fmask);
         bus.in_valid = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         chk($sformatf("v%0d_we", i), rf_we, vt[i].we);
         if (vt[i].we) begin
            chk($sformatf("v%0d_waddr", i), rf_waddr, vt[i].waddr);
            chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].wdata);
         end
         tick();
         chk($sformatf("v%0d_sr", i), sr, vt[i].sr);
         chk($sformatf("v%0d_busy", i), busy, 0);
      end

      // Two-write swap.
      set_pkt(3'd2, 1'b1, 4'd1, 4'd2, 20'd5, 20'd9, 3'b000, 3'b000);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("swp_a_we", rf_we, 1);
      chk("swp_a_addr", rf_waddr, 1);
      chk("swp_a_data", rf_wdata, 5);
      chk("swp_a_rdy", bus.in_ready, 0);
      tick();
      chk("swp_b_we", rf_we, 1);
      chk("swp_b_addr", rf_waddr, 2);
      chk("swp_b_data", rf_wdata, 9);
      chk("swp_b_rdy", bus.in_ready, 0);
      tick();
      chk("swp_end_we", rf_we, 0);
      chk("swp_end_rdy", bus.in_ready, 1);

      // Swap onto one register, next packet taken in its write cycle.
      set_pkt(3'd2, 1'b1, 4'd4, 4'd4, 20'd7, 20'd8, 3'b000, 3'b000);
      bus.in_valid = 1'b1;
      tick();
      chk("dsw_we", rf_we, 1);
      chk("dsw_addr", rf_waddr, 4);
      chk("dsw_data", rf_wdata, 7);
      chk("dsw_rdy", bus.in_ready, 1);
      set_pkt(3'd1, 1'b1, 4'd6, 4'd0, 20'h11, 20'h0, 3'b000, 3'b000);
      tick();
      bus.in_valid = 1'b0;
      chk("dsw_nx_addr", rf_waddr, 6);
      chk("dsw_nx_data", rf_wdata, 20'h11);
      tick();
      chk("dsw_end_we", rf_we, 0);

      // Four ONE packets back to back.
      set_pkt(3'd1, 1'b1, 4'd8, 4'd0, 20'h10000, 20'h0, 3'b0, 3'b0);
      bus.in_valid = 1'b1;
      chk("str_rdy0", bus.in_ready, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("str%0d_we", i), rf_we, 1);
         chk($sformatf("str%0d_addr", i), rf_waddr, 8 + i);
         chk($sformatf("str%0d_data", i), rf_wdata, 20'h10000 + 3 * i);
         if (i < 3) begin
            set_pkt(3'd1, 1'b1, 4'(8 + i + 1), 4'd0,
                    20'(20'h10000 + 3 * (i + 1)), 20'h0, 3'b0, 3'b0);
            chk($sformatf("str%0d_rdy", i), bus.in_ready, 1);
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
      end
      chk("str_end_we", rf_we, 0);

      // Reset while the second swap write is pending.
      set_pkt(3'd4, 1'b1, 4'd0, 4'd0, 20'h7, 20'h0, 3'b0, 3'b0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("rb_sr_pre", sr, 3'b111);
      set_pkt(3'd2, 1'b1, 4'd12, 4'd13, 20'd1, 20'd2, 3'b0, 3'b0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("rb_in_b_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("rb_drop_we", rf_we, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rb_sr", sr, 0);
      chk("rb_rdy", bus.in_ready, 1);
      chk("rb_we", rf_we, 0);
      tick();
      chk("rb_we_next", rf_we, 0);

      // Random stream against the reference model.
      msr  = 3'b000;
      pend = 1'b0;
      q.delete();
      for (int b = 0; b < 4; b++) begin
         for (int c = 0; c < 60; c++) rcycle(1'b1);
         for (int c = 0; c < 6; c++) rcycle(1'b0);
         chk($sformatf("rnd%0d_qempty", b), q.size(), 0);
         chk($sformatf("rnd%0d_sr", b), sr, msr);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
